// File: rtl/neuron_scan_ctrl_if.sv
// Scan-controller bundle: request/abort/config from the sequencer, neuron
// selection and sample handshake back to it and the analog-mux decoder.
interface neuron_scan_ctrl_if #(
  parameter int N_NEURONS = 8,
  parameter int ID_W      = 3,
  parameter int SETTLE_W  = 8
);
  logic                 start;
  logic                 abort;
  logic [N_NEURONS-1:0] enable_mask;
  logic [SETTLE_W-1:0]  settle_cycles;
  logic                 continuous;
  logic                 sample_ack;
  logic [ID_W-1:0]      id;
  logic                 sel_valid;
  logic                 sample_req;
  logic                 busy;
  logic                 done;
  logic [7:0]           frame_cnt;

  modport master (
    output start, abort, enable_mask, settle_cycles, continuous, sample_ack,
    input  id, sel_valid, sample_req, busy, done, frame_cnt
  );

  modport slave (
    input  start, abort, enable_mask, settle_cycles, continuous, sample_ack,
    output id, sel_valid, sample_req, busy, done, frame_cnt
  );
endinterface

// File: rtl/neuron_scan_ctrl.sv
// Walks the enabled neurons in ascending order, waiting settle_cycles+1 clocks
// per neuron for the mux to settle, then handshakes one sample per neuron.
module neuron_scan_ctrl #(
  parameter int N_NEURONS = 8,
  parameter int ID_W      = 3,
  parameter int SETTLE_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  neuron_scan_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_t;

  state_t               r_state;
  logic [N_NEURONS-1:0] r_mask;
  logic [SETTLE_W-1:0]  r_settle;
  logic [SETTLE_W-1:0]  r_cnt;
  logic [ID_W-1:0]      r_id;
  logic                 r_sel_valid;
  logic                 r_sample_req;
  logic                 r_busy;
  logic                 r_done;
  logic [7:0]           r_frame_cnt;

  logic [ID_W-1:0]      w_first_live;
  logic [ID_W-1:0]      w_first_latched;
  logic [ID_W-1:0]      w_next_id;
  logic                 w_has_next;

  // Priority pick by scanning high-to-low so the lowest qualifying bit wins.
  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_first_live    = '0;
    w_first_latched = '0;
    w_next_id       = '0;
    w_has_next      = 1'b0;
    for (int i = N_NEURONS - 1; i >= 0; i--) begin
      if (bus.enable_mask[i]) w_first_live = ID_W'(i);
      if (r_mask[i])          w_first_latched = ID_W'(i);
      if (r_mask[i] && (ID_W'(i) > r_id)) begin
        w_next_id  = ID_W'(i);
        w_has_next = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_mask       <= '0;
      r_settle     <= '0;
      r_cnt        <= '0;
      r_id         <= '0;
      r_sel_valid  <= 1'b0;
      r_sample_req <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_frame_cnt  <= '0;
    end else if (bus.abort && (r_state != S_IDLE)) begin
      // Abort drops the scan silently; id and frame_cnt keep their values.
      r_state      <= S_IDLE;
      r_sel_valid  <= 1'b0;
      r_sample_req <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (bus.start && !bus.abort) begin
            r_frame_cnt <= '0;
            r_busy      <= 1'b1;
            if (|bus.enable_mask) begin
              r_mask      <= bus.enable_mask;
              r_settle    <= bus.settle_cycles;
              r_cnt       <= bus.settle_cycles;
              r_id        <= w_first_live;
              r_sel_valid <= 1'b1;
              r_state     <= S_SETTLE;
            end else begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end
          end
        end
        S_SETTLE: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            r_sample_req <= 1'b1;
            r_state      <= S_SAMPLE;
          end
        end
        S_SAMPLE: begin
          if (bus.sample_ack) begin
            r_sample_req <= 1'b0;
            if (w_has_next) begin
              r_id    <= w_next_id;
              r_cnt   <= r_settle;
              r_state <= S_SETTLE;
            end else if (bus.continuous) begin
              r_id        <= w_first_latched;
              r_cnt       <= r_settle;
              r_frame_cnt <= r_frame_cnt + 8'd1;
              r_state     <= S_SETTLE;
            end else begin
              r_sel_valid <= 1'b0;
              r_done      <= 1'b1;
              r_state     <= S_DONE;
            end
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.id         = r_id;
  assign bus.sel_valid  = r_sel_valid;
  assign bus.sample_req = r_sample_req;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.frame_cnt  = r_frame_cnt;

endmodule

// File: tb/tb_neuron_scan_ctrl.sv
// Directed bench for neuron_scan_ctrl: ordered scan, continuous wrap, empty
// mask, abort, async reset and mid-scan config changes.
module tb_neuron_scan_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec  = 0;
  int   n_fail = 0;

  neuron_scan_ctrl_if #(.N_NEURONS(8), .ID_W(3), .SETTLE_W(8)) bus ();

  neuron_scan_ctrl #(.N_NEURONS(8), .ID_W(3), .SETTLE_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Ticks until sample_req rises; returns the number of ticks, or -1 on timeout.
  task automatic wait_req(output int n);
    n = -1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (bus.sample_req) begin
        n = k;
        break;
      end
    end
  endtask

  int n;

  initial begin
    bus.start         = 1'b0;
    bus.abort         = 1'b0;
    bus.enable_mask   = '0;
    bus.settle_cycles = '0;
    bus.continuous    = 1'b0;
    bus.sample_ack    = 1'b0;
    #1;
    check("rst_id",        32'(bus.id),         32'd0);
    check("rst_sel_valid", 32'(bus.sel_valid),  32'd0);
    check("rst_busy",      32'(bus.busy),       32'd0);
    check("rst_frame_cnt", 32'(bus.frame_cnt),  32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Ascending scan over mask A4: ids 2,5,7, SETTLE lasts 3 cycles each.
    bus.enable_mask   = 8'b1010_0100;
    bus.settle_cycles = 8'd2;
    bus.start         = 1'b1;
    tick();
    bus.start = 1'b0;
    check("a4_busy", 32'(bus.busy), 32'd1);
    for (int s = 0; s < 3; s++) begin
      check("a4_id", 32'(bus.id), (s == 0) ? 32'd2 : (s == 1) ? 32'd5 : 32'd7);
      check("a4_sel_valid", 32'(bus.sel_valid), 32'd1);
      wait_req(n);
      check("a4_settle_len", 32'(n), 32'd3);
      bus.sample_ack = 1'b1;
      tick();
      bus.sample_ack = 1'b0;
    end
    check("a4_done", 32'(bus.done), 32'd1);
    check("a4_done_busy", 32'(bus.busy), 32'd1);
    check("a4_done_sel", 32'(bus.sel_valid), 32'd0);
    tick();
    check("a4_done_pulse", 32'(bus.done), 32'd0);
    check("a4_idle_busy", 32'(bus.busy), 32'd0);
    check("a4_id_held", 32'(bus.id), 32'd7);

    // Single-neuron continuous scan with ack held high.
    bus.enable_mask   = 8'h01;
    bus.settle_cycles = 8'd0;
    bus.continuous    = 1'b1;
    bus.sample_ack    = 1'b1;
    bus.start         = 1'b1;
    tick();
    bus.start = 1'b0;
    check("c_req0", 32'(bus.sample_req), 32'd0);
    for (int k = 1; k <= 3; k++) begin
      tick();
      check("c_req_hi", 32'(bus.sample_req), 32'd1);
      tick();
      check("c_req_lo", 32'(bus.sample_req), 32'd0);
      check("c_frame_cnt", 32'(bus.frame_cnt), 32'(k));
      check("c_id", 32'(bus.id), 32'd0);
    end
    tick();
    check("c_req_last", 32'(bus.sample_req), 32'd1);
    bus.continuous = 1'b0;
    tick();
    check("c_done", 32'(bus.done), 32'd1);
    check("c_frame_final", 32'(bus.frame_cnt), 32'd3);
    bus.sample_ack = 1'b0;
    tick();
    check("c_idle_busy", 32'(bus.busy), 32'd0);

    // Empty mask: immediate done, no selection, frame_cnt cleared.
    bus.enable_mask = 8'h00;
    bus.start       = 1'b1;
    tick();
    bus.start = 1'b0;
    check("z_done", 32'(bus.done), 32'd1);
    check("z_sel_valid", 32'(bus.sel_valid), 32'd0);
    check("z_req", 32'(bus.sample_req), 32'd0);
    check("z_frame_clr", 32'(bus.frame_cnt), 32'd0);
    tick();
    check("z_done_pulse", 32'(bus.done), 32'd0);
    check("z_busy", 32'(bus.busy), 32'd0);

    // Abort coincident with ack after one completed frame.
    bus.enable_mask   = 8'h04;
    bus.settle_cycles = 8'd1;
    bus.continuous    = 1'b1;
    bus.start         = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_req(n);
    check("ab_settle_len", 32'(n), 32'd2);
    bus.sample_ack = 1'b1;
    tick();
    bus.sample_ack = 1'b0;
    check("ab_frame1", 32'(bus.frame_cnt), 32'd1);
    wait_req(n);
    check("ab_settle_len2", 32'(n), 32'd2);
    bus.sample_ack = 1'b1;
    bus.abort      = 1'b1;
    tick();
    bus.sample_ack = 1'b0;
    check("ab_busy", 32'(bus.busy), 32'd0);
    check("ab_sel_valid", 32'(bus.sel_valid), 32'd0);
    check("ab_req", 32'(bus.sample_req), 32'd0);
    check("ab_done", 32'(bus.done), 32'd0);
    check("ab_id", 32'(bus.id), 32'd2);
    check("ab_frame_kept", 32'(bus.frame_cnt), 32'd1);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check("ab_start_ignored", 32'(bus.busy), 32'd0);
    tick();
    check("ab_start_no_done", 32'(bus.done), 32'd0);

    // Async reset during SETTLE of id 5, then a fresh scan of neuron 7.
    bus.enable_mask   = 8'h24;
    bus.settle_cycles = 8'd5;
    bus.continuous    = 1'b0;
    bus.start         = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_req(n);
    bus.sample_ack = 1'b1;
    tick();
    bus.sample_ack = 1'b0;
    check("r_id5", 32'(bus.id), 32'd5);
    tick();
    #1 rst = 1'b1;
    #1;
    check("r_async_id", 32'(bus.id), 32'd0);
    check("r_async_sel", 32'(bus.sel_valid), 32'd0);
    check("r_async_busy", 32'(bus.busy), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    check("r_no_done", 32'(bus.done), 32'd0);
    bus.enable_mask = 8'h80;
    bus.start       = 1'b1;
    tick();
    bus.start = 1'b0;
    check("r_id7", 32'(bus.id), 32'd7);
    wait_req(n);
    check("r_settle_len", 32'(n), 32'd6);
    bus.sample_ack = 1'b1;
    tick();
    bus.sample_ack = 1'b0;
    check("r_done", 32'(bus.done), 32'd1);
    tick();

    // Config and start changes mid-scan are ignored until the scan ends.
    bus.enable_mask   = 8'hFF;
    bus.settle_cycles = 8'd0;
    bus.start         = 1'b1;
    tick();
    bus.enable_mask   = 8'h00;
    bus.settle_cycles = 8'd9;
    for (int s = 0; s < 8; s++) begin
      check("m_id", 32'(bus.id), 32'(s));
      wait_req(n);
      check("m_settle_len", 32'(n), 32'd1);
      bus.sample_ack = 1'b1;
      tick();
      bus.sample_ack = 1'b0;
    end
    bus.start = 1'b0;
    check("m_done", 32'(bus.done), 32'd1);
    tick();
    check("m_idle", 32'(bus.busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
